// File: rtl/pitch_sequencer_if.sv
// Pitch sequencer control/status bundle: requests and configuration in,
// sequencing status and latched configuration out.
interface pitch_sequencer_if;
    logic       pitch_req;
    logic       abort;
    logic [3:0] speedCode;
    logic [1:0] mode;
    logic       busy;
    logic       cfg_lock;
    logic [3:0] step_idx;
    logic       step_strobe;
    logic       done;
    logic       aborted;
    logic [3:0] lat_speed;
    logic [1:0] lat_mode;

    modport master (
        output pitch_req, abort, speedCode, mode,
        input  busy, cfg_lock, step_idx, step_strobe, done, aborted,
               lat_speed, lat_mode
    );

    modport slave (
        input  pitch_req, abort, speedCode, mode,
        output busy, cfg_lock, step_idx, step_strobe, done, aborted,
               lat_speed, lat_mode
    );
endinterface

// File: rtl/pitch_sequencer.sv
// Pitch sequencer: IDLE -> WINDUP -> FLIGHT (16-position LED sweep) -> COOLDOWN,
// timed in prescaled ticks, with abort and speed/mode latching at start.
module pitch_sequencer #(
    parameter int unsigned TICK_CYCLES  = 100000,
    parameter int unsigned WINDUP_TICKS = 500,
    parameter int unsigned COOL_TICKS   = 1000
) (
    input  logic               clk,
    input  logic               rstN,
    pitch_sequencer_if.slave   bus
);
    localparam int unsigned PW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned TM1  = (WINDUP_TICKS > COOL_TICKS) ? WINDUP_TICKS : COOL_TICKS;
    // The tick counter must also reach the longest flight step period (28).
    localparam int unsigned TMAX = (TM1 > 28) ? TM1 : 28;
    localparam int unsigned CW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {IDLE, WINDUP, FLIGHT, COOLDOWN} state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [CW-1:0] tick_cnt;
    logic          req_q;
    logic          busy_r;
    logic [3:0]    step_idx_r;
    logic          step_strobe_r;
    logic          done_r;
    logic          aborted_r;
    logic [3:0]    lat_speed_r;
    logic [1:0]    lat_mode_r;

    logic       tick;
    logic       start;
    logic [4:0] period;
    logic       period_end;

    assign tick       = (presc == PW'(TICK_CYCLES - 1));
    assign start      = (state == IDLE) && bus.pitch_req && !req_q;
    assign period     = 5'd24 - {lat_speed_r, 1'b0} + ((lat_mode_r == 2'd3) ? 5'd4 : 5'd0);
    assign period_end = tick && (tick_cnt == CW'(period - 5'd1));

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state         <= IDLE;
            presc         <= '0;
            tick_cnt      <= '0;
            req_q         <= 1'b0;
            busy_r        <= 1'b0;
            step_idx_r    <= '0;
            step_strobe_r <= 1'b0;
            done_r        <= 1'b0;
            aborted_r     <= 1'b0;
            lat_speed_r   <= 4'd3;
            lat_mode_r    <= 2'd1;
        end else begin
            req_q         <= bus.pitch_req;
            step_strobe_r <= 1'b0;
            done_r        <= 1'b0;
            aborted_r     <= 1'b0;
            presc         <= tick ? '0 : presc + 1'b1;
            if (tick)
                tick_cnt <= tick_cnt + 1'b1;

            // Abort outranks every tick-driven transition in the busy states.
            if (state != IDLE && bus.abort) begin
                state      <= IDLE;
                busy_r     <= 1'b0;
                step_idx_r <= '0;
                aborted_r  <= 1'b1;
                tick_cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        step_idx_r <= '0;
                        if (start) begin
                            state       <= WINDUP;
                            busy_r      <= 1'b1;
                            presc       <= '0;
                            tick_cnt    <= '0;
                            lat_speed_r <= (bus.speedCode > 4'd8) ? 4'd8 : bus.speedCode;
                            lat_mode_r  <= (bus.mode == 2'd0) ? 2'd1 : bus.mode;
                        end
                    end
                    WINDUP: begin
                        if (tick && tick_cnt == CW'(WINDUP_TICKS - 1)) begin
                            state      <= FLIGHT;
                            tick_cnt   <= '0;
                            step_idx_r <= '0;
                        end
                    end
                    FLIGHT: begin
                        if (period_end) begin
                            tick_cnt <= '0;
                            if (step_idx_r != 4'd15) begin
                                step_idx_r    <= step_idx_r + 1'b1;
                                step_strobe_r <= 1'b1;
                            end else begin
                                state <= COOLDOWN;
                            end
                        end
                    end
                    COOLDOWN: begin
                        if (tick && tick_cnt == CW'(COOL_TICKS - 1)) begin
                            state      <= IDLE;
                            busy_r     <= 1'b0;
                            step_idx_r <= '0;
                            done_r     <= 1'b1;
                            tick_cnt   <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy        = busy_r;
    assign bus.cfg_lock    = busy_r;
    assign bus.step_idx    = step_idx_r;
    assign bus.step_strobe = step_strobe_r;
    assign bus.done        = done_r;
    assign bus.aborted     = aborted_r;
    assign bus.lat_speed   = lat_speed_r;
    assign bus.lat_mode    = lat_mode_r;
endmodule

// File: tb/tb_pitch_sequencer.sv
// Bench for pitch_sequencer: cycle-offset reference model compared every cycle,
// plus hand-computed timing, latching, abort and reset expectations.
module tb_pitch_sequencer;
    localparam int T = 2;
    localparam int W = 3;
    localparam int C = 2;

    logic clk = 1'b0;
    logic rstN = 1'b1;
    pitch_sequencer_if bus ();

    pitch_sequencer #(.TICK_CYCLES(T), .WINDUP_TICKS(W), .COOL_TICKS(C)) dut (
        .clk(clk), .rstN(rstN), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Reference model: outputs follow from edges elapsed since the accepted start.
    int cyc = 0;
    bit act = 0;
    bit m_rq = 0;
    int m_start = 0;
    int pt = 0;
    int total = 0;
    int m_ls = 3;
    int m_lm = 1;
    int e_idx = 0;
    bit e_str = 0, e_done = 0, e_abt = 0;

    initial forever begin
        @(posedge clk or negedge rstN);
        if (!rstN) begin
            act = 0; m_rq = 0; m_ls = 3; m_lm = 1;
            e_idx = 0; e_str = 0; e_done = 0; e_abt = 0;
        end else begin
            cyc++;
            e_str = 0; e_done = 0; e_abt = 0;
            if (act && bus.abort) begin
                act = 0; e_abt = 1;
            end else if (act && (cyc - m_start) == total) begin
                act = 0; e_done = 1;
            end else if (!act && bus.pitch_req && !m_rq) begin
                act = 1;
                m_start = cyc;
                m_ls = (bus.speedCode > 8) ? 8 : int'(bus.speedCode);
                m_lm = (bus.mode == 0) ? 1 : int'(bus.mode);
                pt = (24 - 2 * m_ls + ((m_lm == 3) ? 4 : 0)) * T;
                total = W * T + 16 * pt + C * T;
            end
            m_rq = bus.pitch_req;
            e_idx = 0;
            if (act) begin
                int f;
                f = (cyc - m_start) - W * T;
                if (f >= 0) begin
                    if (f < 16 * pt) begin
                        e_idx = f / pt;
                        e_str = (f > 0) && (f % pt == 0);
                    end else begin
                        e_idx = 15;
                    end
                end
            end
        end
    end

    // Per-cycle compare plus event statistics.
    int n_str = 0, last_str = 0, min_sp = 0, max_sp = 0;
    int done_cnt = 0, done_cyc = 0, abt_cnt = 0;

    initial forever begin
        int ev, av;
        @(negedge clk);
        ev = {16'd0, act, act, 4'(e_idx), e_str, e_done, e_abt, 4'(m_ls), 2'(m_lm)};
        av = {16'd0, bus.busy, bus.cfg_lock, bus.step_idx, bus.step_strobe, bus.done,
              bus.aborted, bus.lat_speed, bus.lat_mode};
        chk("outputs{busy,lock,idx,strobe,done,aborted,speed,mode}", av, ev);
        if (bus.step_strobe) begin
            if (n_str > 0) begin
                if (cyc - last_str < min_sp) min_sp = cyc - last_str;
                if (cyc - last_str > max_sp) max_sp = cyc - last_str;
            end
            last_str = cyc;
            n_str++;
        end
        if (bus.done) begin done_cnt++; done_cyc = cyc; end
        if (bus.aborted) abt_cnt++;
    end

    task automatic clear_stats();
        n_str = 0; min_sp = 1000000; max_sp = 0;
    endtask

    task automatic start_pitch(input logic [3:0] spd, input logic [1:0] md);
        @(negedge clk);
        bus.speedCode = spd; bus.mode = md; bus.pitch_req = 1'b1;
        @(negedge clk);
        bus.pitch_req = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int d;
        d = done_cnt;
        for (int i = 0; i < bound && done_cnt == d; i++) @(negedge clk);
        if (done_cnt == d) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int d0, a0;
        bus.pitch_req = 1'b0; bus.abort = 1'b0; bus.speedCode = 4'd0; bus.mode = 2'd0;
        #1 rstN = 1'b0;
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        chk("reset_busy", bus.busy, 0);
        chk("reset_lat_speed", bus.lat_speed, 3);
        chk("reset_lat_mode", bus.lat_mode, 1);
        chk("reset_step_idx", bus.step_idx, 0);

        // Nominal pitch, with a second request edge during FLIGHT.
        clear_stats(); d0 = done_cnt;
        start_pitch(4'd3, 2'd1);
        repeat (100) @(negedge clk);
        bus.pitch_req = 1'b1;
        repeat (2) @(negedge clk);
        bus.pitch_req = 1'b0;
        wait_done(800);
        chk("t1_done_offset", done_cyc - m_start, 586);
        chk("t1_strobes", n_str, 15);
        chk("t1_min_spacing", min_sp, 36);
        chk("t1_max_spacing", max_sp, 36);
        repeat (50) @(negedge clk);
        chk("t1_done_count", done_cnt - d0, 1);

        // Speed clamp and change-up period.
        clear_stats();
        start_pitch(4'd12, 2'd3);
        repeat (3) @(negedge clk);
        chk("t2_lat_speed", bus.lat_speed, 8);
        chk("t2_lat_mode", bus.lat_mode, 3);
        wait_done(600);
        chk("t2_done_offset", done_cyc - m_start, 394);
        chk("t2_min_spacing", min_sp, 24);
        chk("t2_max_spacing", max_sp, 24);

        // Mode 0 mapping; configuration changes while busy must not matter.
        clear_stats();
        start_pitch(4'd0, 2'd0);
        repeat (20) @(negedge clk);
        bus.speedCode = 4'd8; bus.mode = 2'd3;
        chk("t3_lat_mode", bus.lat_mode, 1);
        chk("t3_lat_speed", bus.lat_speed, 0);
        wait_done(1000);
        chk("t3_done_offset", done_cyc - m_start, 778);
        chk("t3_min_spacing", min_sp, 48);
        chk("t3_max_spacing", max_sp, 48);
        chk("t3_strobes", n_str, 15);

        // Abort in IDLE is inert; abort at step 7 ends the pitch.
        a0 = abt_cnt; d0 = done_cnt;
        bus.abort = 1'b1;
        repeat (3) @(negedge clk);
        bus.abort = 1'b0;
        chk("idle_abort_busy", bus.busy, 0);
        chk("idle_abort_count", abt_cnt - a0, 0);
        start_pitch(4'd8, 2'd1);
        for (int i = 0; i < 300 && bus.step_idx != 4'd7; i++) @(negedge clk);
        chk("t4_reach_step7", bus.step_idx, 7);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("t4_aborted", bus.aborted, 1);
        chk("t4_step_idx", bus.step_idx, 0);
        chk("t4_busy", bus.busy, 0);
        @(negedge clk);
        chk("t4_aborted_one_cycle", bus.aborted, 0);
        repeat (300) @(negedge clk);
        chk("t4_no_done", done_cnt - d0, 0);
        chk("t4_abort_count", abt_cnt - a0, 1);

        // Asynchronous reset during WINDUP; request held high across release.
        a0 = abt_cnt; d0 = done_cnt;
        start_pitch(4'd3, 2'd2);
        @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        chk("t5_rst_busy", bus.busy, 0);
        chk("t5_rst_lock", bus.cfg_lock, 0);
        chk("t5_rst_idx", bus.step_idx, 0);
        chk("t5_rst_lat_speed", bus.lat_speed, 3);
        chk("t5_rst_lat_mode", bus.lat_mode, 1);
        bus.pitch_req = 1'b1;
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        chk("t5_start_on_release", bus.busy, 1);
        chk("t5_lat_mode", bus.lat_mode, 2);
        bus.pitch_req = 1'b0;
        chk("t5_no_done", done_cnt - d0, 0);
        chk("t5_no_abort", abt_cnt - a0, 0);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_final_abort", abt_cnt - a0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
